// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module : ifetch_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam int unsigned IFETCH_XLEN = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [IFETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0100_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [IFETCH_XLEN-1:0] pc;
    logic [IFETCH_XLEN-1:0] instr;
  } ifetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ============================================================================
// Module : ifetch_fifo
// Brief  : Synchronous FIFO of (pc, instr) pairs with push/pop/clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  ifetch_entry_t                push_data,
  input  logic                         pop,
  output ifetch_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = $clog2(DEPTH+1);

  ifetch_entry_t        r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_full;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH-1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;
  assign empty  = (r_count == '0);
  assign w_full = (r_count == c_CNT_W'(DEPTH));

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(push && w_full && !clear));
`endif

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : Instruction fetch unit: ROM read requester with redirect flush and
//          a (pc, instr) FIFO to decode. Option macro: IFETCH_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned                DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  read_instr,
  output logic [DATA_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc
);

  localparam int unsigned c_CNT_W = $clog2(DEPTH+1);

  ifetch_state_t          r_state;
  ifetch_state_t          w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_fetch_pc;
  logic [DATA_WIDTH-1:0]  r_issue_pc;
  logic                   r_inflight;

  logic                   w_read;
  logic                   w_redirect;
  logic                   w_room;
  logic                   w_resp_valid;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic [c_CNT_W-1:0]     w_count;
  logic [c_CNT_W:0]       w_occupancy;
  ifetch_entry_t          w_head;
  ifetch_entry_t          w_push_data;

  assign w_redirect   = redirect_valid && (r_state != ST_BOOT);
  // Issue depends only on registered state, never on if_ready.
  assign w_occupancy  = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_room       = (w_occupancy < (c_CNT_W+1)'(DEPTH));
  assign w_resp_valid = r_inflight && (r_state != ST_FLUSH) && !w_redirect;
  assign w_push_data  = '{pc: r_issue_pc, instr: instr_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_read;
      if (w_read) r_issue_pc <= r_fetch_pc;
      if (w_redirect)
        r_fetch_pc <= redirect_pc & ~DATA_WIDTH'(INSTR_BYTES-1);
      else if (w_read)
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(INSTR_BYTES);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_redirect) w_state_nxt = r_inflight ? ST_FLUSH : ST_RUN;
        else            w_read      = w_room;
      end
      ST_FLUSH: begin
        if (w_redirect) w_state_nxt = r_inflight ? ST_FLUSH : ST_RUN;
        else            w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    if_valid = !w_empty;
    if_instr = w_head.instr;
    if_pc    = w_head.pc;
    w_push   = w_resp_valid;
`ifdef IFETCH_BYPASS_EN
    // Empty FIFO: present the response directly; store it only if decode stalls.
    if (w_empty && w_resp_valid) begin
      if_valid = 1'b1;
      if_instr = instr_in;
      if_pc    = r_issue_pc;
      w_push   = !if_ready;
    end
`endif
    w_pop = if_valid && if_ready && !w_empty;
  end

  assign read_instr = w_read;
  assign addr_out   = r_fetch_pc;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed self-checking bench for instr_fetch with a ROM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0100_0000;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
`ifdef IFETCH_BYPASS_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_instr;
  logic [31:0] addr_out;
  logic [31:0] instr_in = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM: data for the sampled address appears the following cycle.
  always @(posedge clk) if (read_instr) instr_in <= addr_out ^ KEY;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .read_instr     (read_instr),
    .addr_out       (addr_out),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // Leaves the bench at the negedge of release, before edge E0.
  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = ready;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (read_instr !== 1'b0) begin failures++; $display("FAIL reset_read actual=%b expected=0", read_instr); end
    checks++; if (addr_out !== RPC) begin failures++; $display("FAIL reset_addr actual=%h expected=%h", addr_out, RPC); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h expected=0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=0", if_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset(1'b1);
    checks++; if (read_instr !== 1'b0) begin failures++; $display("FAIL boot_read actual=%b expected=0", read_instr); end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      checks++;
      if (read_instr !== 1'b1 || addr_out !== RPC + 32'(4*(n-1))) begin
        failures++; $display("FAIL stream_read n=%0d actual=%b/%h expected=1/%h", n, read_instr, addr_out, RPC + 32'(4*(n-1)));
      end
      checks++;
      if (if_valid !== (n >= FIRST)) begin
        failures++; $display("FAIL stream_valid n=%0d actual=%b expected=%b", n, if_valid, n >= FIRST);
      end else if (n >= FIRST) begin
        epc = RPC + 32'(4*(n-FIRST));
        checks++;
        if (if_pc !== epc || if_instr !== (epc ^ KEY)) begin
          failures++; $display("FAIL stream_pair n=%0d actual=%h/%h expected=%h/%h", n, if_pc, if_instr, epc, epc ^ KEY);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int reads;
    logic [31:0] epc;
    reads = 0;
    do_reset(1'b0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (read_instr) reads++;
      if (n >= FIRST) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_instr !== (RPC ^ KEY)) begin
          failures++; $display("FAIL hold n=%0d actual=%b/%h/%h expected=1/%h/%h", n, if_valid, if_pc, if_instr, RPC, RPC ^ KEY);
        end
      end
    end
    checks++; if (reads != 4) begin failures++; $display("FAIL bp_reads actual=%0d expected=4", reads); end
    if_ready = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      epc = RPC + 32'(4*j);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== epc || if_instr !== (epc ^ KEY)) begin
        failures++; $display("FAIL drain j=%0d actual=%b/%h/%h expected=1/%h/%h", j, if_valid, if_pc, if_instr, epc, epc ^ KEY);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    found = 1'b0;
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0103;
    #1;
    checks++; if (read_instr !== 1'b0) begin failures++; $display("FAIL rdi_read actual=%b expected=0", read_instr); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (read_instr !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL rdi_flush actual=%b/%b expected=0/0", read_instr, if_valid);
    end
    @(negedge clk);
    checks++;
    if (read_instr !== 1'b1 || addr_out !== 32'h0100_0100) begin
      failures++; $display("FAIL rdi_addr actual=%b/%h expected=1/01000100", read_instr, addr_out);
    end
    for (int k = 0; k < 5 && !found; k++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        checks++;
        if (if_pc !== 32'h0100_0100 || if_instr !== (32'h0100_0100 ^ KEY)) begin
          failures++; $display("FAIL rdi_first actual=%h/%h expected=01000100/%h", if_pc, if_instr, 32'h0100_0100 ^ KEY);
        end
      end
    end
    if (!found) begin checks++; failures++; $display("FAIL rdi_timeout actual=no_valid expected=valid"); end
  endtask

  task automatic test_redirect_handshake();
    bit found;
    found = 1'b0;
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0200_0000;
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RPC || read_instr !== 1'b0) begin
      failures++; $display("FAIL rdh_xfer actual=%b/%h/%b expected=1/%h/0", if_valid, if_pc, read_instr, RPC);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || read_instr !== 1'b1 || addr_out !== 32'h0200_0000) begin
      failures++; $display("FAIL rdh_next actual=%b/%b/%h expected=0/1/02000000", if_valid, read_instr, addr_out);
    end
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        checks++;
        if (if_pc !== 32'h0200_0000) begin failures++; $display("FAIL rdh_first actual=%h expected=02000000", if_pc); end
      end
    end
    if (!found) begin checks++; failures++; $display("FAIL rdh_timeout actual=no_valid expected=valid"); end
  endtask

  task automatic test_wrap();
    logic [31:0] got [3];
    logic [31:0] exp [3];
    int nrd;
    nrd = 0;
    exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 10 && nrd < 3; k++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      if (read_instr) begin got[nrd] = addr_out; nrd++; end
    end
    if (nrd < 3) begin
      checks++; failures++; $display("FAIL wrap_timeout actual=%0d expected=3", nrd);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin failures++; $display("FAIL wrap_addr i=%0d actual=%h expected=%h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (read_instr !== 1'b0 || addr_out !== RPC || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      failures++; $display("FAIL async_rst actual=%b/%h/%b/%h/%h expected=0/%h/0/0/0", read_instr, addr_out, if_valid, if_instr, if_pc, RPC);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (read_instr !== 1'b0) begin failures++; $display("FAIL rst_boot actual=%b expected=0", read_instr); end
    @(negedge clk);
    checks++;
    if (read_instr !== 1'b1 || addr_out !== RPC) begin
      failures++; $display("FAIL rst_restart actual=%b/%h expected=1/%h", read_instr, addr_out, RPC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_handshake();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the requesting end of the instruction ROM read interface. It drives `read_instr`/`addr_out` into the ROM, captures the returned word one cycle later, and buffers (pc, instr) pairs in a small FIFO presented to decode through a valid/ready handshake. It handles redirects (branch/jump) by flushing buffered and in-flight fetches.

## Interface
- `DATA_WIDTH`, 32, instruction and address width
- `RESET_PC`, 32'h0100_0000, first fetch address after reset
- `DEPTH`, 4, FIFO entries (legal 2..8)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `read_instr`  out  1  ROM read strobe
- `addr_out`  out  DATA_WIDTH  ROM byte address
- `instr_in`  in  DATA_WIDTH  ROM data, valid the cycle after `read_instr`
- `redirect_valid`  in  1  replace fetch PC
- `redirect_pc`  in  DATA_WIDTH  new fetch address
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid pair
- `if_ready`  in  1  decode accepts the pair
- `if_instr`  out  DATA_WIDTH  instruction to decode
- `if_pc`  out  DATA_WIDTH  address of `if_instr`

## Operation
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: entered on reset; lasts one cycle, no read; then RUN.
  - RUN: `read_instr`=1 when `count + inflight < DEPTH` (no `if_ready` term; no comb path `if_ready`→`read_instr`). `addr_out`=`fetch_pc`; on issue `fetch_pc += 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - `redirect_valid` in any state except BOOT: `read_instr`=0 that cycle; `fetch_pc <= {redirect_pc[31:2],2'b00}`; FIFO cleared; go to FLUSH if a read is in flight, else stay RUN.
  - FLUSH: one cycle; arriving `instr_in` discarded; `read_instr`=0; then RUN.
- `inflight` (1 bit) = `read_instr` registered; when set and not squashed, push {issued pc, `instr_in`}.
- Pop when `if_valid && if_ready`; simultaneous push and pop leave `count` unchanged.
- Redirect in the same cycle as a handshake: transfer counts as accepted by decode; FIFO still cleared.
- Redirect in BOOT is ignored.
- Push never occurs when full (guaranteed by issue rule); overflow is an assertion failure.

## Timing
- Reset values: `read_instr`=0, `addr_out`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0; `count`=0, `inflight`=0, `fetch_pc`=`RESET_PC`, state BOOT.
- After `rst` deasserts, rising edges E0, E1, …:
  - E0: BOOT.
  - E1: first read of `RESET_PC`.
  - E2: data pushed.
  - E3: `if_valid`=1.
- Issue→`if_valid`: 2 cycles without bypass.
- Redirect→first redirected `read_instr`: next cycle if nothing is in flight, otherwise 2 cycles.
- Throughput: sustained 1 instr/cycle with `if_ready` held high requires `DEPTH`≥3.
- `if_valid`/`if_instr`/`if_pc` are stable while `if_valid && !if_ready`.
- `rst` mid-operation: all state and outputs return to reset values immediately.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a non-squashed response arrives, `instr_in`/its pc drive `if_instr`/`if_pc` combinationally with `if_valid`=1.
  - If `if_ready`=1 the response is not pushed; otherwise it is pushed.
  - Issue→`if_valid` latency becomes 1 cycle (first `if_valid` at E2).
- Undefined: every response goes through the FIFO; latency 2.

## Structure
- Package `ifetch_pkg`:
  - state enum (BOOT, RUN, FLUSH)
  - `ifetch_entry_t` struct {pc, instr}
  - default `RESET_PC`
  - `INSTR_BYTES`=4
- Sub-module `ifetch_fifo`: parameterised synchronous FIFO of `ifetch_entry_t`, with push/pop/clear, `count`, async active-high `rst`.
- FSM, PC and issue logic stay in `instr_fetch`.

## Test plan
- Reset release, `if_ready`=1, ROM model returning addr^0xA5A5A5A5 → reads at 0x01000000, 0x01000004, …; first `if_valid` at E3 (E2 with bypass); then one pair per cycle with matching pc.
- `if_ready`=0 for 10 cycles → exactly `DEPTH` reads issued; `if_instr`/`if_pc` held; on release all 4 pairs delivered in order with no gap or loss.
- Redirect to 0x01000103 while a read is in flight → stale response discarded; next `addr_out`=0x01000100; no `if_valid` with old pc after redirect.
- Redirect and handshake in the same cycle → one pair transferred, FIFO empty next cycle, new pc fetched.
- `fetch_pc` redirected to 0xFFFFFFF8 → reads 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- `rst` pulsed asynchronously mid-stream with FIFO at 3 entries → outputs at reset values before the next edge; restart fetches `RESET_PC`.
